// File: rtl/bsg_inv_fifo_if.sv
// Handshake bundle for bsg_inv_fifo.
//   slave  : seen by the FIFO (takes data_i/v_i/yumi_i, drives ready_o/v_o/data_o/count_o)
//   master : seen by the producer/consumer side
// Signals:
//   data_i  [width_p]  write data          v_i     write valid
//   ready_o            can accept a word   v_o     output word valid
//   data_o  [width_p]  ~oldest stored word yumi_i  consumer takes the output word
//   count_o            occupancy 0..els_p
interface bsg_inv_fifo_if #(
  parameter int width_p = 16,
  parameter int els_p   = 2
);
  localparam int count_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]    data_i;
  logic                  v_i;
  logic                  ready_o;
  logic                  v_o;
  logic [width_p-1:0]    data_o;
  logic                  yumi_i;
  logic [count_w_lp-1:0] count_o;

  modport slave (
    input  data_i, v_i, yumi_i,
    output ready_o, v_o, data_o, count_o
  );

  modport master (
    output data_i, v_i, yumi_i,
    input  ready_o, v_o, data_o, count_o
  );
endinterface

// File: rtl/bsg_inv_fifo.sv
// bsg_inv_fifo: els_p-deep circular buffer in front of the bit-inverter.
// Words enter on a valid/ready port and leave, bitwise inverted, on a
// valid/yumi port. All outputs come from registered state only, so there is
// no combinational path from any input to any output.
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   reset_n_i  asynchronous active-low reset
//   fifo_if    handshake bundle (slave modport), see bsg_inv_fifo_if
module bsg_inv_fifo #(
  parameter int width_p = 16,
  parameter int els_p   = 2
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  bsg_inv_fifo_if.slave     fifo_if
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [width_p-1:0]  mem_d [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  logic enq, deq;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(els_p - 1)) next_ptr = '0;
    else                           next_ptr = p + ptr_w_lp'(1);
  endfunction

  // Flags come from the registered count only; ready_o deliberately ignores
  // yumi_i so a full buffer never bypasses.
  assign fifo_if.ready_o = (count_q < cnt_w_lp'(els_p));
  assign fifo_if.v_o     = (count_q != '0);
  assign fifo_if.data_o  = ~mem_q[rd_ptr_q];
  assign fifo_if.count_o = count_q;

  // yumi_i without v_o is dropped here so pointers and count stay consistent.
  assign enq = fifo_if.v_i    & fifo_if.ready_o;
  assign deq = fifo_if.yumi_i & fifo_if.v_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = fifo_if.data_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (deq) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage resets to all ones so data_o reads zero straight out of reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < els_p; i++) begin
        mem_q[i] <= '1;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Flag consumers that take a word that is not there.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(fifo_if.yumi_i && !fifo_if.v_o))
        else $error("bsg_inv_fifo: yumi_i asserted while v_o is low");
    end
  end

endmodule

// File: tb/tb_bsg_inv_fifo.sv
// Directed bench for bsg_inv_fifo: a depth-2 instance covers reset, single
// word, fill/backpressure, full with simultaneous v_i/yumi_i and mid-run
// reset; a depth-3 instance covers streaming across pointer wrap.
// Expected output words are pushed to a queue when a word is driven in and
// popped when the DUT presents it.
module tb_bsg_inv_fifo;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bsg_inv_fifo_if #(.width_p(16), .els_p(2)) if2 ();
  bsg_inv_fifo_if #(.width_p(16), .els_p(3)) if3 ();

  bsg_inv_fifo #(.width_p(16), .els_p(2)) dut2 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .fifo_if   (if2)
  );

  bsg_inv_fifo #(.width_p(16), .els_p(3)) dut3 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .fifo_if   (if3)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] q2[$];
  logic [15:0] q3[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enqueue one word on the depth-2 instance (one cycle).
  task automatic enq2(input logic [15:0] d, input logic [15:0] exp_out);
    if2.data_i = d;
    if2.v_i    = 1'b1;
    q2.push_back(exp_out);
    step();
    if2.v_i    = 1'b0;
  endtask

  // Compare head of depth-2 instance against the scoreboard, then take it.
  task automatic pop2(input string tag);
    logic [15:0] exp;
    chk({tag, "_v"}, if2.v_o, 1'b1);
    if (q2.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      exp = q2.pop_front();
      chk({tag, "_data"}, if2.data_o, exp);
    end
    if2.yumi_i = 1'b1;
    step();
    if2.yumi_i = 1'b0;
  endtask

  initial begin
    int received;
    logic [15:0] exp3;

    rst_n      = 1'b1;
    if2.data_i = '0; if2.v_i = 1'b0; if2.yumi_i = 1'b0;
    if3.data_i = '0; if3.v_i = 1'b0; if3.yumi_i = 1'b0;

    // Reset asserted mid-clock, before any rising edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_v2",     if2.v_o,     1'b0);
    chk("rst_ready2", if2.ready_o, 1'b1);
    chk("rst_count2", if2.count_o, 0);
    chk("rst_data2",  if2.data_o,  16'h0000);
    chk("rst_v3",     if3.v_o,     1'b0);
    chk("rst_count3", if3.count_o, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single word.
    enq2(16'hA5F0, 16'h5A0F);
    chk("single_count1", if2.count_o, 1);
    pop2("single");
    chk("single_v_after",     if2.v_o,     1'b0);
    chk("single_count_after", if2.count_o, 0);

    // Fill and backpressure.
    enq2(16'h0001, 16'hFFFE);
    enq2(16'hFFFE, 16'h0001);
    chk("full_count", if2.count_o, 2);
    chk("full_ready", if2.ready_o, 1'b0);
    if2.data_i = 16'h1234;
    if2.v_i    = 1'b1;
    step();
    if2.v_i    = 1'b0;
    chk("full_count_hold", if2.count_o, 2);
    chk("full_ready_hold", if2.ready_o, 1'b0);
    pop2("drain_a");
    pop2("drain_b");
    chk("drain_count", if2.count_o, 0);
    chk("drain_v",     if2.v_o,     1'b0);

    // Full with simultaneous v_i and yumi_i: only the dequeue happens.
    enq2(16'hAAAA, 16'h5555);
    enq2(16'hBBBB, 16'h4444);
    chk("fullsim_count2", if2.count_o, 2);
    if2.data_i = 16'h00FF;
    if2.v_i    = 1'b1;
    pop2("fullsim_pop");
    chk("fullsim_count1", if2.count_o, 1);
    chk("fullsim_ready",  if2.ready_o, 1'b1);
    // v_i still high with 16'h00FF; accepted now.
    q2.push_back(16'hFF00);
    step();
    if2.v_i = 1'b0;
    chk("fullsim_count_refill", if2.count_o, 2);
    pop2("fullsim_a");
    pop2("fullsim_b");
    chk("fullsim_empty", if2.count_o, 0);

    // Streaming on depth 3, yumi_i follows v_o.
    received = 0;
    for (int cyc = 0; cyc < 40 && received < 10; cyc++) begin
      if (if3.v_o) begin
        if (q3.size() == 0) begin
          chk("stream_sb_empty", 1, 0);
        end else begin
          exp3 = q3.pop_front();
          chk($sformatf("stream_data%0d", received), if3.data_o, exp3);
        end
        received++;
        if3.yumi_i = 1'b1;
      end else begin
        if3.yumi_i = 1'b0;
      end
      if (cyc >= 1 && cyc <= 9) begin
        chk($sformatf("stream_count_c%0d", cyc), if3.count_o, 1);
      end
      if (cyc < 10) begin
        chk($sformatf("stream_ready_c%0d", cyc), if3.ready_o, 1'b1);
        if3.data_i = 16'(cyc);
        if3.v_i    = 1'b1;
        q3.push_back(~16'(cyc));
      end else begin
        if3.v_i = 1'b0;
      end
      step();
    end
    if3.v_i    = 1'b0;
    if3.yumi_i = 1'b0;
    chk("stream_received", received, 10);
    chk("stream_final_count", if3.count_o, 0);
    chk("stream_final_v",     if3.v_o,     1'b0);

    // Reset in the middle of operation discards stored words.
    enq2(16'h1111, 16'hEEEE);
    enq2(16'h2222, 16'hDDDD);
    chk("midrst_pre_count", if2.count_o, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", if2.count_o, 0);
    chk("midrst_v",     if2.v_o,     1'b0);
    chk("midrst_data",  if2.data_o,  16'h0000);
    q2.delete();
    step();
    rst_n = 1'b1;
    step();
    enq2(16'hC3C3, 16'h3C3C);
    chk("midrst_count1", if2.count_o, 1);
    pop2("midrst_word");
    chk("midrst_drained_v",     if2.v_o,     1'b0);
    chk("midrst_drained_count", if2.count_o, 0);
    step();
    chk("midrst_no_stale", if2.v_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
